mcu_hid_decoder: RTL
====================

Name: mcu_hid_decoder

Overview:
- Consumes the HID-target byte stream from the SPI MCU interface: byte strobe, frame-start qualifier and 8-bit data.
- Parses short command frames into three outputs: keyboard events, accumulated mouse motion and joystick state.
- These outputs feed the core's keyboard/mouse/joystick emulation.
- Runs entirely in the core clock domain; all inputs are already synchronous to clk.

Parameters:
- KEY_FIFO_DEPTH, 8, keyboard event FIFO depth; power of two, 2..16.
- NUM_JOY, 2, number of joystick state registers; 1..4.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- hid_strobe  in  1  one-cycle pulse: data_in is a valid HID payload byte
- hid_start  in  1  qualifies a strobe as the first payload byte (command byte) of a frame
- data_in  in  8  payload byte
- key_valid  out  1  key FIFO not empty
- key_code  out  8  FIFO head; bit7=1 release, bits6:0 scancode
- key_ack  in  1  pop FIFO head; ignored when empty
- key_overflow  out  1  sticky: a key event was dropped because the FIFO was full
- mouse_buttons  out  3  latest button state (bit0 left, bit1 right, bit2 middle)
- mouse_dx  out  8  signed accumulated X motion since last mouse_ack
- mouse_dy  out  8  signed accumulated Y motion since last mouse_ack
- mouse_ack  in  1  consumer has read dx/dy; clears both accumulators
- joy_state  out  8*NUM_JOY  joystick n in bits [8n+7:8n]; bits 3:0 = up/down/left/right, bit4 = fire, bits 7:5 reserved

Behaviour:
- Reset: FIFO empty, key_valid=0, key_overflow=0, mouse_*=0, joy_state=0, parser in IDLE.
- Parser states: IDLE, KBD, MOUSE, JOY, SKIP. A 2-bit byte index counts payload bytes after the command byte.
- A strobe with hid_start=1 is a command byte, accepted in any state; it aborts any partial frame and resets the byte index to 0.
  - 0x01 -> KBD
  - 0x02 -> MOUSE
  - 0x03 -> JOY
  - any other value -> SKIP
- A strobe with hid_start=0 while in IDLE is ignored.
- KBD: every following byte is pushed to the FIFO; a frame may carry any number of bytes.
- MOUSE: byte0 latches mouse_buttons[2:0]; byte1 is held as dx; byte2 is dy.
  - On byte2, both accumulators add their signed delta with saturation to [-128,+127].
  - Parser then goes to SKIP.
  - A frame that ends before byte2 changes no accumulator; buttons still update if byte0 arrived.
- JOY: byte0 is the joystick index; byte1 is written to that index's register if index < NUM_JOY, else discarded. Parser then goes to SKIP.
- SKIP: further bytes are ignored until the next command byte.
- Latency: outputs update on the clock edge that samples the strobe; they are visible the cycle after the strobe.
- FIFO push while full: event dropped, key_overflow set.
  - key_overflow clears on the next accepted key_ack, unless the same cycle also drops an event.
- Simultaneous push and pop: both occur; this holds when full (new byte accepted, no overflow) and when empty (no effect).
- key_code is valid only while key_valid=1; it updates the cycle after a pop.
- mouse_ack in the same cycle as an accumulate: accumulator = 0 + delta (new motion is not lost).
- mouse_ack with no accumulate: both accumulators cleared next cycle.
- Reset asserted mid-frame clears everything immediately. A frame already in progress when reset releases is ignored until the next hid_start.

Test Plan:
- Keyboard frame: start+0x01, then 0x1E, 0x9E -> key_valid=1, key_code=0x1E; key_ack -> 0x9E; key_ack -> key_valid=0.
- Overflow: 9 key bytes without ack (depth 8) -> 8 stored, key_overflow=1; one key_ack -> key_overflow=0, 7 remain.
- Mouse saturation: frames (0x01, dx=0x70, dy=0x90) twice -> mouse_buttons=1, mouse_dx=0x7F, mouse_dy=0x80; mouse_ack -> both 0.
- Ack collision: mouse_ack asserted in the same cycle as the dy strobe of frame (0, 0x05, 0xFB) -> mouse_dx=0x05, mouse_dy=0xFB.
- Joystick: start+0x03, 0x01, 0x11 -> joy_state[15:8]=0x11, [7:0] unchanged; index 0x05 -> no register changes.
- Abort/unknown: start+0x02, 0x01, 0x10, then start+0x01, 0x2A -> mouse_buttons=1, dx/dy unchanged, key_code=0x2A; start+0x7F then bytes -> no output changes.

Source files
------------

// File: rtl/mcu_hid_if.sv
// HID byte-stream input plus keyboard/mouse/joystick output bundle.
// Latency: none (wiring only).
// Backpressure: none; key_ack and mouse_ack are the consumer's only return path.
interface mcu_hid_if #(
    parameter int NUM_JOY = 2
);
    logic                   hid_strobe;
    logic                   hid_start;
    logic [7:0]             data_in;
    logic                   key_valid;
    logic [7:0]             key_code;
    logic                   key_ack;
    logic                   key_overflow;
    logic [2:0]             mouse_buttons;
    logic [7:0]             mouse_dx;
    logic [7:0]             mouse_dy;
    logic                   mouse_ack;
    logic [8*NUM_JOY-1:0]   joy_state;

    // Producer of the byte stream and consumer of the decoded state.
    modport master (
        output hid_strobe, hid_start, data_in, key_ack, mouse_ack,
        input  key_valid, key_code, key_overflow, mouse_buttons,
               mouse_dx, mouse_dy, joy_state
    );

    // The decoder itself.
    modport slave (
        input  hid_strobe, hid_start, data_in, key_ack, mouse_ack,
        output key_valid, key_code, key_overflow, mouse_buttons,
               mouse_dx, mouse_dy, joy_state
    );
endinterface

// File: rtl/mcu_hid_decoder.sv
// Small synchronous FIFO; head is presented combinationally from storage.
// Latency: a push is visible at dout the cycle after it is sampled.
// Backpressure: push while full is refused unless a pop happens the same cycle.
module mcu_hid_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; pop and push may happen together, including when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// Decodes HID command frames into key events, mouse motion and joystick state.
// Latency: outputs update on the edge sampling the strobe, visible next cycle.
// Backpressure: none on the byte stream; full key FIFO drops and flags overflow.
module mcu_hid_decoder #(
    parameter int KEY_FIFO_DEPTH = 8,
    parameter int NUM_JOY        = 2
) (
    input  logic      clk,
    input  logic      reset,
    mcu_hid_if.slave  hid
);
    typedef enum logic [2:0] {IDLE, KBD, MOUSE, JOY, SKIP} state_t;

    state_t               state;
    logic [1:0]           idx;
    logic [7:0]           hold;       // dx in mouse frames, joystick index in joy frames
    logic [2:0]           buttons;
    logic signed [7:0]    dx;
    logic signed [7:0]    dy;
    logic [8*NUM_JOY-1:0] joy;
    logic                 overflow;

    logic                 payload;
    logic                 key_push;
    logic                 key_pop;
    logic                 key_drop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [7:0]           fifo_head;
    logic signed [7:0]    dx_base;
    logic signed [7:0]    dy_base;

    assign payload  = hid.hid_strobe && !hid.hid_start;
    assign key_push = payload && (state == KBD);
    assign key_pop  = hid.key_ack && !fifo_empty;
    assign key_drop = key_push && fifo_full && !key_pop;

    // An ack landing with an accumulate restarts from zero so new motion survives.
    assign dx_base = hid.mouse_ack ? 8'sd0 : dx;
    assign dy_base = hid.mouse_ack ? 8'sd0 : dy;

    function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                   input logic signed [7:0] b);
        logic signed [8:0] s;
        s = $signed({a[7], a}) + $signed({b[7], b});
        if (s > 9'sd127)       return 8'sh7F;
        else if (s < -9'sd128) return 8'sh80;
        else                   return s[7:0];
    endfunction

    mcu_hid_fifo #(.DEPTH(KEY_FIFO_DEPTH), .WIDTH(8)) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (key_push),
        .pop   (hid.key_ack),
        .din   (hid.data_in),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Frame parser with registered mouse and joystick outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 2'd0;
            hold    <= 8'd0;
            buttons <= 3'd0;
            dx      <= 8'sd0;
            dy      <= 8'sd0;
            joy     <= '0;
        end else begin
            if (hid.mouse_ack) begin
                dx <= 8'sd0;
                dy <= 8'sd0;
            end
            if (hid.hid_strobe) begin
                if (hid.hid_start) begin
                    idx <= 2'd0;
                    case (hid.data_in)
                        8'h01:   state <= KBD;
                        8'h02:   state <= MOUSE;
                        8'h03:   state <= JOY;
                        default: state <= SKIP;
                    endcase
                end else begin
                    case (state)
                        MOUSE: begin
                            idx <= idx + 2'd1;
                            case (idx)
                                2'd0: buttons <= hid.data_in[2:0];
                                2'd1: hold    <= hid.data_in;
                                2'd2: begin
                                    dx    <= sat_add(dx_base, hold);
                                    dy    <= sat_add(dy_base, hid.data_in);
                                    state <= SKIP;
                                end
                                default: state <= SKIP;
                            endcase
                        end
                        JOY: begin
                            idx <= idx + 2'd1;
                            if (idx == 2'd0) begin
                                hold <= hid.data_in;
                            end else begin
                                for (int n = 0; n < NUM_JOY; n++) begin
                                    if (hold == 8'(n)) joy[8*n +: 8] <= hid.data_in;
                                end
                                state <= SKIP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as an ack keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         overflow <= 1'b0;
        else if (key_drop) overflow <= 1'b1;
        else if (key_pop)  overflow <= 1'b0;
    end

    assign hid.key_valid     = !fifo_empty;
    assign hid.key_code      = fifo_head;
    assign hid.key_overflow  = overflow;
    assign hid.mouse_buttons = buttons;
    assign hid.mouse_dx      = dx;
    assign hid.mouse_dy      = dy;
    assign hid.joy_state     = joy;
endmodule
